// File: rtl/instr_encoder_writer.sv
// Packs instruction fields into 32-bit words and streams them into instruction memory
// through a small FIFO, under control of a start-delimited load session.
module instr_encoder_writer #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned MEM_DEPTH  = 256,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        tipo,
   input  logic [1:0]        op,
   input  logic              inm,
   input  logic [3:0]        rd,
   input  logic [3:0]        rs1,
   input  logic [3:0]        rs2,
   input  logic [11:0]       imm,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_written
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(MEM_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
   localparam logic [PTR_W:0]    FIFO_CAP  = (PTR_W + 1)'(FIFO_DEPTH);

   logic [1:0]        state_q, state_d;
   logic [31:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    count_q, count_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   written_q;
   logic [ADDR_W:0]   accepted_q;
   logic              err_q, done_q;

   logic        fifo_full, fifo_empty, illegal, accept, push, pop;
   logic [31:0] enc_word;

   assign fifo_full  = (count_q == FIFO_CAP);
   assign fifo_empty = (count_q == '0);

   // Legal-word budget is tracked at acceptance so the session never overruns memory.
   assign in_ready = (state_q == S_LOAD) && !fifo_full && (accepted_q < DEPTH_CNT);
   assign illegal  = ((tipo == 2'b01) || (tipo == 2'b10)) && !inm;
   assign accept   = in_valid && in_ready;
   assign push     = accept && !illegal;

   assign mem_we   = !fifo_empty && (state_q != S_IDLE);
   assign pop      = mem_we && mem_ready;

   assign enc_word = {tipo, op, inm, rd, rs1, (inm ? 4'd0 : rs2), 3'b000,
                      (inm ? imm : 12'd0)};

   assign mem_wdata     = mem_we ? fifo_mem[rd_ptr_q] : 32'd0;
   assign mem_addr      = addr_q;
   assign words_written = written_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = done_q;
   assign err           = err_q;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_LOAD;
         S_LOAD:  if (start || (push && (accepted_q + 1'b1 == DEPTH_CNT))) state_d = S_DRAIN;
         S_DRAIN: if (count_d == '0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         addr_q     <= '0;
         written_q  <= '0;
         accepted_q <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         err_q   <= accept && illegal;
         done_q  <= (state_q == S_DRAIN) && (state_d == S_IDLE);
         if (push) begin
            wr_ptr_q   <= wr_ptr_q + 1'b1;
            accepted_q <= accepted_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            written_q <= written_q + 1'b1;
            // Saturate so the final word leaves the address at the last location.
            if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
         end
         if ((state_q == S_IDLE) && start) begin
            addr_q     <= '0;
            written_q  <= '0;
            accepted_q <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= enc_word;
   end

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Directed bench: table of encoding vectors plus hand-written session sequences.
// Instance a uses the default depth; instance b uses a 4-word session.
module tb_instr_encoder_writer;

   typedef struct {
      logic [1:0]  tipo;
      logic [1:0]  op;
      logic        inm;
      logic [3:0]  rd;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic [11:0] imm;
      logic [31:0] exp;
      logic        bad;
   } vec_t;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start_a, start_b, in_valid, mem_ready, inm;
   logic [1:0]  tipo, op;
   logic [3:0]  rd, rs1, rs2;
   logic [11:0] imm;

   logic        in_ready_a, mem_we_a, busy_a, done_a, err_a;
   logic [7:0]  mem_addr_a;
   logic [31:0] mem_wdata_a;
   logic [8:0]  ww_a;
   logic        in_ready_b, mem_we_b, busy_b, done_b, err_b;
   logic [7:0]  mem_addr_b;
   logic [31:0] mem_wdata_b;
   logic [8:0]  ww_b;

   instr_encoder_writer u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(in_ready_a),
      .tipo(tipo), .op(op), .inm(inm), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .mem_we(mem_we_a), .mem_ready(mem_ready), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wdata_a), .busy(busy_a), .done(done_a), .err(err_a),
      .words_written(ww_a)
   );

   instr_encoder_writer #(.MEM_DEPTH(4)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(in_ready_b),
      .tipo(tipo), .op(op), .inm(inm), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .mem_we(mem_we_b), .mem_ready(mem_ready), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .busy(busy_b), .done(done_b), .err(err_b),
      .words_written(ww_b)
   );

   wr_t log_a[$];
   wr_t log_b[$];

   always @(posedge clk) begin
      if (!rst && mem_we_a && mem_ready) log_a.push_back('{mem_addr_a, mem_wdata_a});
      if (!rst && mem_we_b && mem_ready) log_b.push_back('{mem_addr_b, mem_wdata_b});
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v);
      tipo = v.tipo; op = v.op; inm = v.inm;
      rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
   endtask

   // Plain R-type stream word; expected value built from the field layout.
   function automatic vec_t mk(input int i);
      vec_t v;
      v.tipo = 2'b00;
      v.op   = 2'(i);
      v.inm  = 1'b0;
      v.rd   = 4'(i);
      v.rs1  = 4'(i + 1);
      v.rs2  = 4'(i + 2);
      v.imm  = 12'hFFF;
      v.bad  = 1'b0;
      v.exp  = {2'b00, v.op, 1'b0, v.rd, v.rs1, v.rs2, 15'h0};
      return v;
   endfunction

   task automatic send(input vec_t v);
      bit ok;
      apply(v);
      in_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 64 && !ok; c++) begin
         @(negedge clk);
         ok = in_ready_a;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("send_accepted", 32'(ok), 32'd1);
   endtask

   task automatic pulse_start_a();
      start_a = 1'b1;
      step();
      start_a = 1'b0;
   endtask

   task automatic wait_done_a();
      bit   seen;
      logic busy_at;
      seen = 1'b0;
      busy_at = 1'b1;
      for (int c = 0; c < 64 && !seen; c++) begin
         @(negedge clk);
         if (done_a) begin
            seen = 1'b1;
            busy_at = busy_a;
         end
         @(posedge clk);
         #1;
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("busy_low_at_done", 32'(busy_at), 32'd0);
   endtask

   task automatic wait_log_a(input int n);
      for (int c = 0; c < 64 && log_a.size() < n; c++) step();
      chk("log_a_count", log_a.size(), n);
   endtask

   vec_t vecs[7];
   int   base, legal_n, acc, dones;
   bit   hs, prev_busy;
   logic [31:0] held_data;

   initial begin
      vecs[0] = '{2'b00, 2'b01, 1'b0, 4'd3, 4'd1, 4'd2, 12'hABC, 32'h11890000, 1'b0};
      vecs[1] = '{2'b01, 2'b00, 1'b1, 4'd5, 4'd4, 4'd7, 12'h123, 32'h4AA00123, 1'b0};
      vecs[2] = '{2'b10, 2'b11, 1'b0, 4'd1, 4'd2, 4'd3, 12'h456, 32'h0, 1'b1};
      vecs[3] = '{2'b10, 2'b10, 1'b1, 4'hF, 4'h0, 4'h9, 12'hFFF, 32'hAF800FFF, 1'b0};
      vecs[4] = '{2'b11, 2'b11, 1'b0, 4'h0, 4'hF, 4'hF, 12'h555, 32'hF07F8000, 1'b0};
      vecs[5] = '{2'b01, 2'b01, 1'b0, 4'h6, 4'h6, 4'h6, 12'h666, 32'h0, 1'b1};
      vecs[6] = '{2'b00, 2'b00, 1'b1, 4'h1, 4'h2, 4'h3, 12'h800, 32'h08900800, 1'b0};

      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
      apply(mk(0));
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready_a), 32'd0);
      chk("rst_mem_we", 32'(mem_we_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done_err", {30'd0, done_a, err_a}, 32'd0);
      chk("rst_addr", 32'(mem_addr_a), 32'd0);
      chk("rst_words", 32'(ww_a), 32'd0);
      chk("rst_wdata", mem_wdata_a, 32'd0);
      chk("rst_busy_b", 32'(busy_b), 32'd0);
      @(posedge clk);
      #1;

      // Encoding table: each vector alone, write side free-running.
      pulse_start_a();
      legal_n = 0;
      for (int i = 0; i < 7; i++) begin
         send(vecs[i]);
         @(negedge clk);
         chk($sformatf("vec%0d_err", i), 32'(err_a), 32'(vecs[i].bad));
         chk($sformatf("vec%0d_we", i), 32'(mem_we_a), 32'(!vecs[i].bad));
         if (!vecs[i].bad) chk($sformatf("vec%0d_data", i), mem_wdata_a, vecs[i].exp);
         chk($sformatf("vec%0d_addr", i), 32'(mem_addr_a), 32'(legal_n));
         @(posedge clk);
         #1;
         @(negedge clk);
         chk($sformatf("vec%0d_quiet", i), {30'd0, mem_we_a, err_a}, 32'd0);
         @(posedge clk);
         #1;
         if (!vecs[i].bad) legal_n++;
      end
      chk("vec_words", 32'(ww_a), 32'd5);
      chk("vec_log", log_a.size(), 32'd5);
      pulse_start_a();
      wait_done_a();

      // Backpressure: FIFO fills, outputs hold while memory stalls.
      base = log_a.size();
      pulse_start_a();
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(mk(i));
      @(negedge clk);
      held_data = mk(0).exp;
      for (int k = 0; k < 5; k++) begin
         chk("bp_in_ready", 32'(in_ready_a), 32'd0);
         chk("bp_we", 32'(mem_we_a), 32'd1);
         chk("bp_addr", 32'(mem_addr_a), 32'd0);
         chk("bp_data", mem_wdata_a, held_data);
         @(posedge clk);
         #1;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b1;
      send(mk(4));
      send(mk(5));
      wait_log_a(base + 6);
      for (int i = 0; i < 6 && base + i < log_a.size(); i++) begin
         chk($sformatf("bp_log_addr%0d", i), 32'(log_a[base+i].addr), 32'(i));
         chk($sformatf("bp_log_data%0d", i), log_a[base+i].data, mk(i).exp);
      end
      chk("bp_words", 32'(ww_a), 32'd6);
      pulse_start_a();
      wait_done_a();

      // Depth limit on the 4-word instance: 6 offered, 4 taken.
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      acc = 0; dones = 0; prev_busy = 1'b1;
      apply(mk(0));
      in_valid = 1'b1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         hs = in_ready_b;
         if (done_b) begin
            dones++;
            chk("lim_busy_at_done", 32'(busy_b), 32'd0);
            chk("lim_busy_before_done", 32'(prev_busy), 32'd1);
         end
         prev_busy = busy_b;
         @(posedge clk);
         #1;
         if (hs) begin
            acc++;
            if (acc < 6) apply(mk(acc));
         end
      end
      in_valid = 1'b0;
      chk("lim_accepted", 32'(acc), 32'd4);
      chk("lim_dones", 32'(dones), 32'd1);
      chk("lim_words", 32'(ww_b), 32'd4);
      chk("lim_addr", 32'(mem_addr_b), 32'd3);
      chk("lim_in_ready", 32'(in_ready_b), 32'd0);
      chk("lim_log", log_b.size(), 32'd4);
      for (int i = 0; i < 4 && i < log_b.size(); i++) begin
         chk($sformatf("lim_log_addr%0d", i), 32'(log_b[i].addr), 32'(i));
         chk($sformatf("lim_log_data%0d", i), log_b[i].data, mk(i).exp);
      end

      // Second start closes the session with two words still queued.
      base = log_a.size();
      pulse_start_a();
      mem_ready = 1'b0;
      for (int i = 10; i < 13; i++) send(mk(i));
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      pulse_start_a();
      @(negedge clk);
      chk("eop_busy", 32'(busy_a), 32'd1);
      chk("eop_in_ready", 32'(in_ready_a), 32'd0);
      @(posedge clk);
      #1;
      mem_ready = 1'b1;
      wait_done_a();
      chk("eop_log", log_a.size(), base + 3);
      for (int i = 0; i < 3 && base + i < log_a.size(); i++) begin
         chk($sformatf("eop_log_addr%0d", i), 32'(log_a[base+i].addr), 32'(i));
         chk($sformatf("eop_log_data%0d", i), log_a[base+i].data, mk(10 + i).exp);
      end
      chk("eop_words", 32'(ww_a), 32'd3);

      pulse_start_a();
      @(negedge clk);
      chk("restart_addr", 32'(mem_addr_a), 32'd0);
      chk("restart_words", 32'(ww_a), 32'd0);
      chk("restart_busy", 32'(busy_a), 32'd1);
      @(posedge clk);
      #1;
      base = log_a.size();
      send(mk(7));
      wait_log_a(base + 1);
      if (log_a.size() > base) begin
         chk("restart_log_addr", 32'(log_a[base].addr), 32'd0);
         chk("restart_log_data", log_a[base].data, mk(7).exp);
      end

      // Reset in the middle of a drain with three words queued.
      mem_ready = 1'b0;
      for (int i = 1; i < 4; i++) send(mk(20 + i));
      pulse_start_a();
      @(negedge clk);
      chk("mid_drain_busy", 32'(busy_a), 32'd1);
      chk("mid_drain_we", 32'(mem_we_a), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_we", 32'(mem_we_a), 32'd0);
      chk("mrst_busy", 32'(busy_a), 32'd0);
      chk("mrst_in_ready", 32'(in_ready_a), 32'd0);
      chk("mrst_wdata", mem_wdata_a, 32'd0);
      chk("mrst_words", 32'(ww_a), 32'd0);
      chk("mrst_addr", 32'(mem_addr_a), 32'd0);
      chk("mrst_done_err", {30'd0, done_a, err_a}, 32'd0);
      base = log_a.size();
      mem_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         chk("mrst_idle_we", 32'(mem_we_a), 32'd0);
      end
      chk("mrst_no_writes", log_a.size(), base);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
